// File: rtl/contador_programa_pilha.sv
// contador_programa_pilha
//   Program counter for the SAP datapath with a modulo terminal value and
//   CALL/RET support through an internal return-address stack.
//   Q drives the instruction address bus; it sits between the control
//   sequencer and the memory address register.
//
// Ports
//   clock          rising-edge clock
//   clear          asynchronous active-low reset
//   enable         increment Q this cycle
//   load           Q <= DATA (jump)
//   call           push return address (next sequential), Q <= DATA
//   ret            pop top of stack into Q
//   DATA           jump/call target
//   Q              current count (registered)
//   terminal       Q >= MAX_COUNT (combinational)
//   stack_full     level == DEPTH (combinational)
//   stack_empty    level == 0 (combinational)
//   level          number of valid stack entries (registered)
//   overflow_err   sticky, call attempted while full
//   underflow_err  sticky, ret attempted while empty
//
// Priority per edge: load > call > ret > enable; one action per cycle.

module contador_programa_pilha #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int MAX_COUNT = 2**WIDTH - 1,
    localparam int LW       = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             enable,
    input  logic             load,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] DATA,
    output logic [WIDTH-1:0] Q,
    output logic             terminal,
    output logic             stack_full,
    output logic             stack_empty,
    output logic [LW-1:0]    level,
    output logic             overflow_err,
    output logic             underflow_err
);

    // Stack index width; the array is padded to a power of two so that an
    // index of exactly IW bits addresses it without width mismatches.
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SD = 2**IW;

    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_COUNT);
    localparam logic [LW-1:0]    DEPTH_W = LW'(DEPTH);

    logic [WIDTH-1:0] stack [SD];
    logic [WIDTH-1:0] nxt;
    logic [LW-1:0]    level_dec;
    logic [IW-1:0]    push_idx;
    logic [IW-1:0]    pop_idx;

    assign terminal    = (Q >= MAX_W);
    assign stack_full  = (level == DEPTH_W);
    assign stack_empty = (level == '0);

    // Values above MAX_COUNT (reachable through load) also wrap to 0.
    assign nxt = terminal ? '0 : Q + WIDTH'(1);

    assign level_dec = level - LW'(1);
    assign push_idx  = level[IW-1:0];
    assign pop_idx   = level_dec[IW-1:0];

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            Q             <= '0;
            level         <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
            for (int i = 0; i < SD; i++) begin
                stack[i] <= '0;
            end
        end else if (load) begin
            Q <= DATA;
        end else if (call) begin
            // A call while full is dropped entirely, including any enable.
            if (stack_full) begin
                overflow_err <= 1'b1;
            end else begin
                stack[push_idx] <= nxt;
                level           <= level + LW'(1);
                Q               <= DATA;
            end
        end else if (ret) begin
            if (stack_empty) begin
                underflow_err <= 1'b1;
            end else begin
                Q     <= stack[pop_idx];
                level <= level_dec;
            end
        end else if (enable) begin
            Q <= nxt;
        end
    end

endmodule

// File: tb/tb_contador_programa_pilha.sv
module tb_contador_programa_pilha;

    logic       clock = 1'b0;
    logic       clear = 1'b1;
    logic       enable = 1'b0, load = 1'b0, call = 1'b0, ret = 1'b0;
    logic [7:0] data = 8'h00;

    // dut_a: MAX_COUNT = 9, dut_b: MAX_COUNT = 255; inputs are shared.
    logic [7:0] q_a, q_b;
    logic [2:0] lvl_a, lvl_b;
    logic       term_a, full_a, empty_a, ovf_a, unf_a;
    logic       term_b, full_b, empty_b, ovf_b, unf_b;

    contador_programa_pilha #(.WIDTH(8), .DEPTH(4), .MAX_COUNT(9)) dut_a (
        .clock(clock), .clear(clear), .enable(enable), .load(load),
        .call(call), .ret(ret), .DATA(data), .Q(q_a), .terminal(term_a),
        .stack_full(full_a), .stack_empty(empty_a), .level(lvl_a),
        .overflow_err(ovf_a), .underflow_err(unf_a));

    contador_programa_pilha #(.WIDTH(8), .DEPTH(4), .MAX_COUNT(255)) dut_b (
        .clock(clock), .clear(clear), .enable(enable), .load(load),
        .call(call), .ret(ret), .DATA(data), .Q(q_b), .terminal(term_b),
        .stack_full(full_b), .stack_empty(empty_b), .level(lvl_b),
        .overflow_err(ovf_b), .underflow_err(unf_b));

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    typedef struct {
        int         sel;
        logic [7:0] q;
        logic [2:0] lvl;
        logic       ovf;
        logic       unf;
        int         due;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    event chk_now;

    function automatic logic [15:0] pack_exp(exp_t e);
        logic term;
        term = (e.sel != 0) ? (e.q >= 8'd255) : (e.q >= 8'd9);
        return {e.q, e.lvl, term, e.lvl == 3'd4, e.lvl == 3'd0, e.ovf, e.unf};
    endfunction

    function automatic logic [15:0] pack_act(int sel);
        if (sel != 0)
            return {q_b, lvl_b, term_b, full_b, empty_b, ovf_b, unf_b};
        return {q_a, lvl_a, term_a, full_a, empty_a, ovf_a, unf_a};
    endfunction

    task automatic check_due();
        exp_t e;
        logic [15:0] w, g;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            w = pack_exp(e);
            g = pack_act(e.sel);
            n_cmp++;
            if (g !== w) begin
                n_bad++;
                $display("FAIL %s (dut %0d): got q=%h lvl=%0d term=%b full=%b empty=%b ovf=%b unf=%b, need q=%h lvl=%0d term=%b full=%b empty=%b ovf=%b unf=%b",
                         e.name, e.sel, g[15:8], g[7:5], g[4], g[3], g[2], g[1], g[0],
                         w[15:8], w[7:5], w[4], w[3], w[2], w[1], w[0]);
            end
        end
    endtask

    // Monitor: each negedge (or an explicit mid-cycle request) compares
    // every expectation whose due cycle has been reached.
    initial begin
        forever begin
            @(negedge clock or chk_now);
            check_due();
        end
    end

    task automatic push_exp(input int sel, input logic [7:0] q, input logic [2:0] lvl,
                            input logic ovf, input logic unf, input string name, input int due);
        exp_t e;
        e.sel = sel; e.q = q; e.lvl = lvl; e.ovf = ovf; e.unf = unf;
        e.due = due; e.name = name;
        sb.push_back(e);
    endtask

    // One action per cycle; the expected state is due after the next edge.
    task automatic step(input logic en, input logic ld, input logic cl, input logic rt,
                        input logic [7:0] d, input int sel, input logic [7:0] q,
                        input logic [2:0] lvl, input logic ovf, input logic unf,
                        input string name);
        @(negedge clock);
        #1;
        enable = en; load = ld; call = cl; ret = rt; data = d;
        push_exp(sel, q, lvl, ovf, unf, name, cyc + 1);
    endtask

    task automatic pulse_clear(input string name);
        @(negedge clock);
        #1;
        enable = 0; load = 0; call = 0; ret = 0; data = 8'h00;
        clear = 1'b0;
        #1;
        push_exp(0, 8'h00, 3'd0, 1'b0, 1'b0, name, cyc);
        push_exp(1, 8'h00, 3'd0, 1'b0, 1'b0, name, cyc);
        -> chk_now;
        @(negedge clock);
        #1;
        clear = 1'b1;
    endtask

    logic [7:0] cnt_tab [12] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                                 8'h07, 8'h08, 8'h09, 8'h00, 8'h01, 8'h02};

    initial begin
        // Reset state, taken asynchronously between edges.
        #1 clear = 1'b0;
        #1;
        push_exp(0, 8'h00, 3'd0, 1'b0, 1'b0, "reset", cyc);
        push_exp(1, 8'h00, 3'd0, 1'b0, 1'b0, "reset", cyc);
        -> chk_now;
        @(negedge clock);
        #1 clear = 1'b1;

        // 1. count with wrap at MAX_COUNT=9
        for (int i = 0; i < 12; i++)
            step(1, 0, 0, 0, 8'h00, 0, cnt_tab[i], 3'd0, 0, 0, "count");

        // 2. load priority and load above MAX_COUNT
        step(1, 0, 0, 0, 8'h00, 0, 8'h03, 3'd0, 0, 0, "count_to_3");
        step(1, 1, 1, 0, 8'h40, 0, 8'h40, 3'd0, 0, 0, "load_prio");
        step(0, 1, 0, 0, 8'hC8, 0, 8'hC8, 3'd0, 0, 0, "load_c8");
        step(1, 0, 0, 0, 8'h00, 0, 8'h00, 3'd0, 0, 0, "wrap_from_c8");

        pulse_clear("clear_1");

        // 3. nested call/ret on MAX_COUNT=255
        step(0, 1, 0, 0, 8'h10, 1, 8'h10, 3'd0, 0, 0, "load_10");
        step(0, 0, 1, 0, 8'h80, 1, 8'h80, 3'd1, 0, 0, "call_80");
        step(1, 0, 0, 0, 8'h00, 1, 8'h81, 3'd1, 0, 0, "inc_81");
        step(1, 0, 0, 0, 8'h00, 1, 8'h82, 3'd1, 0, 0, "inc_82");
        step(0, 0, 1, 0, 8'hA0, 1, 8'hA0, 3'd2, 0, 0, "call_a0");
        step(0, 0, 0, 1, 8'h00, 1, 8'h83, 3'd1, 0, 0, "ret_83");
        step(0, 0, 0, 1, 8'h00, 1, 8'h11, 3'd0, 0, 0, "ret_11");
        step(0, 0, 1, 1, 8'h30, 1, 8'h30, 3'd1, 0, 0, "call_ret_both");
        step(0, 0, 0, 1, 8'h00, 1, 8'h12, 3'd0, 0, 0, "ret_12");

        // push address wraps when calling from MAX_COUNT
        step(0, 1, 0, 0, 8'hFF, 1, 8'hFF, 3'd0, 0, 0, "load_ff");
        step(0, 0, 1, 0, 8'h07, 1, 8'h07, 3'd1, 0, 0, "call_from_ff");
        step(0, 0, 0, 1, 8'h00, 1, 8'h00, 3'd0, 0, 0, "ret_wrap_0");

        // 4. overflow
        step(0, 1, 0, 0, 8'h00, 1, 8'h00, 3'd0, 0, 0, "load_00");
        step(0, 0, 1, 0, 8'h20, 1, 8'h20, 3'd1, 0, 0, "call_1");
        step(0, 0, 1, 0, 8'h20, 1, 8'h20, 3'd2, 0, 0, "call_2");
        step(0, 0, 1, 0, 8'h20, 1, 8'h20, 3'd3, 0, 0, "call_3");
        step(0, 0, 1, 0, 8'h20, 1, 8'h20, 3'd4, 0, 0, "call_4_full");
        step(1, 0, 1, 0, 8'h55, 1, 8'h20, 3'd4, 1, 0, "call_5_overflow");
        step(0, 0, 0, 1, 8'h00, 1, 8'h21, 3'd3, 1, 0, "ret_a");
        step(0, 0, 0, 1, 8'h00, 1, 8'h21, 3'd2, 1, 0, "ret_b");
        step(0, 0, 0, 1, 8'h00, 1, 8'h21, 3'd1, 1, 0, "ret_c");
        step(0, 0, 0, 1, 8'h00, 1, 8'h01, 3'd0, 1, 0, "ret_d");

        // 5. underflow and stickiness
        step(0, 1, 0, 0, 8'h05, 1, 8'h05, 3'd0, 1, 0, "load_05");
        step(1, 0, 0, 1, 8'h00, 1, 8'h05, 3'd0, 1, 1, "ret_underflow");
        step(1, 0, 0, 0, 8'h00, 1, 8'h06, 3'd0, 1, 1, "inc_sticky");
        step(0, 0, 0, 0, 8'h00, 1, 8'h06, 3'd0, 1, 1, "idle_hold");

        pulse_clear("clear_2");

        // 6. async reset in the middle of a call at level 2
        step(0, 0, 1, 0, 8'h10, 1, 8'h10, 3'd1, 0, 0, "pre_call_1");
        step(0, 0, 1, 0, 8'h20, 1, 8'h20, 3'd2, 0, 0, "pre_call_2");
        @(negedge clock);
        #1;
        call = 1'b0; data = 8'h40; call = 1'b1;
        #1 clear = 1'b0;
        #1;
        push_exp(1, 8'h00, 3'd0, 1'b0, 1'b0, "async_clear", cyc);
        -> chk_now;
        @(negedge clock);
        #1;
        push_exp(1, 8'h00, 3'd0, 1'b0, 1'b0, "held_in_clear", cyc);
        -> chk_now;
        call = 1'b0;
        clear = 1'b1;
        step(0, 0, 0, 1, 8'h00, 1, 8'h00, 3'd0, 0, 1, "no_push_in_clear");
        step(1, 0, 0, 0, 8'h00, 1, 8'h01, 3'd0, 0, 1, "inc_after_clear");

        // drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && sb.size() > 0; k++)
            @(negedge clock);
        #2;
        if (sb.size() > 0) begin
            $display("FAIL drain: got %0d pending, need 0", sb.size());
            n_cmp += sb.size();
            n_bad += sb.size();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, need completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/contador_programa_pilha.md
Name: contador_programa_pilha

Overview:
- Parametrised program counter, successor to the fixed 4-bit synchronous counter in the SAP datapath.
- Adds configurable width, a modulo terminal value, CALL/RET support via an internal return-address stack of configurable depth, status flags, and sticky error flags.
- Sits between the control sequencer and the memory address register.
- Q drives the instruction address bus.

Parameters:
- WIDTH, 8, width of the counter and of DATA.
- DEPTH, 4, number of return-address stack entries (>=1).
- MAX_COUNT, 2**WIDTH-1, last count value before wrap to 0 (1 .. 2**WIDTH-1).

Ports:
- clock  input  1  rising-edge clock.
- clear  input  1  asynchronous active-low reset.
- enable  input  1  increment Q this cycle.
- load  input  1  Q <= DATA (jump).
- call  input  1  push return address, Q <= DATA.
- ret  input  1  pop top of stack into Q.
- DATA  input  WIDTH  jump/call target.
- Q  output  WIDTH  current count (registered).
- terminal  output  1  combinational, high when Q >= MAX_COUNT.
- stack_full  output  1  combinational, high when level == DEPTH.
- stack_empty  output  1  combinational, high when level == 0.
- level  output  clog2(DEPTH+1)  number of valid stack entries (registered).
- overflow_err  output  1  sticky, set on call while full.
- underflow_err  output  1  sticky, set on ret while empty.

Behaviour:
- Reset (clear low, asynchronous, takes effect immediately regardless of clock):
  - Q=0, level=0, overflow_err=0, underflow_err=0, all stack entries =0.
  - Reset mid-operation discards any pending action.
  - First action after release is evaluated on the first rising edge with clear high.
- All other updates occur on the rising edge of clock.
- Priority per edge: load > call > ret > enable. Exactly one action is performed per cycle.
- load, call and ret act regardless of enable.
- Next-sequential value NXT: 0 if Q >= MAX_COUNT, else Q+1. Arithmetic is WIDTH bits.
- load:
  - Q <= DATA, loaded unmodified even if DATA > MAX_COUNT.
  - The next increment from such a value wraps to 0.
  - Stack is untouched.
- call, not full:
  - stack[level] <= NXT, level <= level+1, Q <= DATA.
- call while full:
  - No push; Q and level unchanged; overflow_err <= 1.
  - Any enable in that cycle is ignored.
- ret, not empty:
  - Q <= stack[level-1], level <= level-1.
  - The popped entry's contents are don't-care afterwards.
- ret while empty:
  - Q and level unchanged; underflow_err <= 1.
  - Any enable in that cycle is ignored.
- enable only: Q <= NXT.
- No action asserted: all state holds.
- call and ret together: call wins; ret is ignored and no error is flagged for ret.
- Latency: every action is visible on Q one edge after the inputs are sampled.
  - terminal, stack_full and stack_empty follow Q/level combinationally.
- Error flags: once set they stay set until clear; they never block later legal operations.
- Stack is LIFO. The push address is always NXT of the Q at the time of the call, wrap included.

Test Plan:
1. Reset and count (WIDTH=8, MAX_COUNT=9):
   - Release clear, enable for 12 cycles -> Q = 1..9, 0, 1, 2.
   - terminal high only while Q=9.
2. Load priority:
   - With Q=3, assert load=1, enable=1, call=1, DATA=0x40 -> Q=0x40, level unchanged.
   - With DATA=0xC8, load then enable -> Q=0xC8, then 0.
3. Nested call/ret (DEPTH=4, MAX_COUNT=255):
   - Q=0x10: call DATA=0x80 -> Q=0x80, level=1.
   - Enable twice -> Q=0x82.
   - call DATA=0xA0 -> level=2.
   - ret -> Q=0x83, ret -> Q=0x11, stack_empty=1.
4. Overflow:
   - Five consecutive calls from Q=0x00 with DATA=0x20 (DEPTH=4).
   - After 4th: stack_full=1, level=4.
   - 5th: Q stays 0x20, level 4, overflow_err=1.
   - Four rets then return 0x21, 0x21, 0x21, 0x01.
5. Underflow and stickiness:
   - ret at level=0 with Q=0x05 -> Q=0x05, underflow_err=1.
   - Subsequent enable -> Q=0x06, underflow_err still 1.
   - Pulse clear -> all outputs 0.
6. Async reset mid-call:
   - Assert clear low between edges while call=1 and level=2 -> Q=0, level=0 immediately, before the next edge.
   - No push occurs on the edge while clear is low.
